axi_burst_arbiter: RTL and testbench
====================================

Name: axi_burst_arbiter

Overview:
- Next-generation memory-side arbiter and AXI master for the CPU core.
- Replaces the fixed two-way cache_miss mux plus single-beat AXI interface.
- Takes NUM_PORT cache refill/writeback ports, grants one at a time round-robin, and issues either a single-beat access or a BURST_LEN-beat INCR burst on AXI3.
- Sits between i_cache/d_cache (and future uncached/TLB ports) and the SoC AXI crossbar.

Parameters:
NUM_PORT, 2, number of requesting ports (1..8)
BURST_LEN, 4, beats per burst request (power of two, 2..16)
DATA_W, 32, AXI and port data width (fixed 32 in this generation)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
req_valid  in  NUM_PORT  per-port request; held until matching done pulse
req_write  in  NUM_PORT  1 = write, 0 = read
req_burst  in  NUM_PORT  1 = BURST_LEN-beat burst, 0 = single beat
req_addr  in  32*NUM_PORT  byte address, port i at [32i+31:32i]
req_size  in  2*NUM_PORT  single-beat size (0 byte, 1 half, 2 word); ignored for bursts
req_strb  in  4*NUM_PORT  single-beat write strobes; bursts use 4'b1111
req_wdata  in  32*NUM_PORT  current write beat; advance after wbeat_ack
grant  out  NUM_PORT  one-hot owner of current transaction, 0 when idle
rdata_o  out  32  read beat data, shared
rdata_valid  out  NUM_PORT  pulse per read beat to granted port
wbeat_ack  out  NUM_PORT  pulse when granted port's write beat is accepted
done  out  NUM_PORT  pulse at transaction end
err  out  1  with done: 1 if any rresp/bresp != 0 in transaction
ar*/r*/aw*/w*/b*  AXI3 master channels, same names and widths as the existing axi_interface; arid/awid/wid = 0, arburst/awburst = 2'b01, lock/cache/prot = 0

Behaviour:
- States: IDLE, AR, R, AW, W, B.
- Reset (aresetn low at a clock edge):
  - state IDLE, grant = 0.
  - All valids (arvalid, awvalid, wvalid) and ready outputs (rready, bready) 0.
  - rdata_valid, wbeat_ack, done, err all 0.
  - Round-robin pointer = port 0.
  - Reset mid-transaction abandons it with no done pulse.
- IDLE:
  - Arbitration searches from the port after the last granted one, wrapping; first active req_valid wins.
  - Registers grant, then go to AR (read) or AW (write) in the next cycle.
  - No request: stay in IDLE.
- Address:
  - Burst: low log2(BURST_LEN*4) bits forced to 0, len = BURST_LEN-1, size = 3'b010.
  - Single: address unmodified, len = 0, size = {1'b0, req_size}.
- AR: arvalid = 1 and held stable until arready; then go to R.
- R:
  - rready = 1.
  - Each rvalid beat: rdata_o = rdata, rdata_valid[g] pulses that same cycle (combinational from rvalid).
  - On rlast: done[g] = 1, err = sticky OR of rresp != 0, go to IDLE.
- AW: awvalid held until awready; then go to W. AW and W are never overlapped.
- W:
  - wvalid = 1, wdata = req_wdata of the granted port.
  - wstrb = req_strb (single) or 4'b1111 (burst).
  - 5-bit beat counter; wlast = 1 when counter = len.
  - Each wready: wbeat_ack[g] pulses, counter increments. After the last beat, go to B.
- B:
  - bready = 1.
  - On bvalid: done[g] pulses, err = sticky err | (bresp != 0), go to IDLE.
- Pointer update:
  - The round-robin pointer updates only when done pulses.
  - IDLE is entered for at least one cycle between transactions, so back-to-back latency is 1 idle cycle.
- Port-side rules:
  - Deasserting req_valid mid-transaction is ignored; the AXI transaction always completes.
  - New requests that arrive while busy wait.
- done and grant clear together: grant = 0 in the cycle after done.

Test Plan:
- Single read: port0 addr 0x1FC0_0004, size 2 → araddr 0x1FC0_0004, arlen 0, arsize 2. Slave returns 0xDEADBEEF with rlast → rdata_valid[0] and done[0] same cycle, err 0.
- Burst read, BURST_LEN = 4: port1 addr 0x0000_1238 → araddr 0x0000_1230, arlen 3. Four beats with slave rvalid gaps → exactly 4 rdata_valid[1] pulses in order, done[1] on the 4th.
- Burst write: port1 supplies 0x11, 0x22, 0x33, 0x44 advancing on wbeat_ack, with wready stalling 2 cycles → wdata sequence exact, wlast only on beat 4, wstrb 1111; done after bvalid; bresp = 2'b10 → err = 1.
- Round-robin: ports 0 and 1 both request continuously → grants alternate 0, 1, 0, 1; port 1 idle → port 0 served back-to-back with 1 idle cycle between.
- Stall: arready low 5 cycles → arvalid and araddr stable throughout, state stays AR.
- Reset mid-burst after 2 of 4 read beats → next cycle all outputs 0, grant 0, no done pulse; a fresh request afterwards issues a new AR.

Source files
------------

// File: rtl/axi_burst_arbiter.sv
// rtl/axi_burst_arbiter.sv - round-robin multi-port arbiter and AXI3 single/burst master
// One transaction in flight; AW and W are serialized, rdata/beat/done strobes follow the granted port.
module axi_burst_arbiter #(
   parameter int NUM_PORT  = 2,
   parameter int BURST_LEN = 4,
   parameter int DATA_W    = 32
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_PORT-1:0]          req_valid,
   input  logic [NUM_PORT-1:0]          req_write,
   input  logic [NUM_PORT-1:0]          req_burst,
   input  logic [32*NUM_PORT-1:0]       req_addr,
   input  logic [2*NUM_PORT-1:0]        req_size,
   input  logic [4*NUM_PORT-1:0]        req_strb,
   input  logic [DATA_W*NUM_PORT-1:0]   req_wdata,
   output logic [NUM_PORT-1:0]          grant,
   output logic [DATA_W-1:0]            rdata_o,
   output logic [NUM_PORT-1:0]          rdata_valid,
   output logic [NUM_PORT-1:0]          wbeat_ack,
   output logic [NUM_PORT-1:0]          done,
   output logic                         err,
   output logic [3:0]                   arid,
   output logic [31:0]                  araddr,
   output logic [3:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic [1:0]                   arlock,
   output logic [3:0]                   arcache,
   output logic [2:0]                   arprot,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [DATA_W-1:0]            rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready,
   output logic [3:0]                   awid,
   output logic [31:0]                  awaddr,
   output logic [3:0]                   awlen,
   output logic [2:0]                   awsize,
   output logic [1:0]                   awburst,
   output logic [1:0]                   awlock,
   output logic [3:0]                   awcache,
   output logic [2:0]                   awprot,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [3:0]                   wid,
   output logic [DATA_W-1:0]            wdata,
   output logic [3:0]                   wstrb,
   output logic                         wlast,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic [1:0]                   bresp,
   input  logic                         bvalid,
   output logic                         bready
);

   localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
   localparam int BURST_SHIFT = $clog2(BURST_LEN) + 2;
   localparam logic [31:0] BURST_MASK = ~((32'd1 << BURST_SHIFT) - 32'd1);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

   state_t                state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         gidx;
   logic [PW-1:0]         ptr_next;
   logic [31:0]           addr_q;
   logic [3:0]            len_q;
   logic [2:0]            size_q;
   logic                  burst_q;
   logic                  err_q;
   logic [4:0]            wcnt;

   logic                  win_found;
   logic [PW-1:0]         win_idx;
   logic [PW-1:0]         cand;
   logic [NUM_PORT-1:0]   win_onehot;
   logic [31:0]           win_addr;

   // Search starts at ptr, which is always the port after the last one that completed.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      cand       = '0;
      win_onehot = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
         cand = PW'((int'(ptr) + i) % NUM_PORT);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_onehot[win_idx] = 1'b1;
      win_addr = req_addr[32*win_idx +: 32];
   end

   assign ptr_next = PW'((int'(gidx) + 1) % NUM_PORT);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= S_IDLE;
         grant   <= '0;
         gidx    <= '0;
         ptr     <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= 1'b0;
         err_q   <= 1'b0;
         wcnt    <= '0;
         arvalid <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         rready  <= 1'b0;
         bready  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  grant   <= win_onehot;
                  gidx    <= win_idx;
                  burst_q <= req_burst[win_idx];
                  err_q   <= 1'b0;
                  wcnt    <= '0;
                  if (req_burst[win_idx]) begin
                     addr_q <= win_addr & BURST_MASK;
                     len_q  <= 4'(BURST_LEN - 1);
                     size_q <= 3'b010;
                  end else begin
                     addr_q <= win_addr;
                     len_q  <= 4'd0;
                     size_q <= {1'b0, req_size[2*win_idx +: 2]};
                  end
                  if (req_write[win_idx]) begin
                     awvalid <= 1'b1;
                     state   <= S_AW;
                  end else begin
                     arvalid <= 1'b1;
                     state   <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_R;
               end
            end
            S_R: begin
               if (rvalid) begin
                  err_q <= err_q | (rresp != 2'b00);
                  if (rlast) begin
                     rready <= 1'b0;
                     grant  <= '0;
                     ptr    <= ptr_next;
                     state  <= S_IDLE;
                  end
               end
            end
            S_AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  state   <= S_W;
               end
            end
            S_W: begin
               if (wready) begin
                  wcnt <= wcnt + 5'd1;
                  if (wlast) begin
                     wvalid <= 1'b0;
                     bready <= 1'b1;
                     state  <= S_B;
                  end
               end
            end
            S_B: begin
               if (bvalid) begin
                  err_q  <= err_q | (bresp != 2'b00);
                  bready <= 1'b0;
                  grant  <= '0;
                  ptr    <= ptr_next;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic r_beat, w_beat, fin, beat_err;

   assign r_beat   = (state == S_R) && rvalid;
   assign w_beat   = (state == S_W) && wready;
   assign fin      = (r_beat && rlast) || ((state == S_B) && bvalid);
   assign beat_err = (state == S_R) ? (rresp != 2'b00) : (bresp != 2'b00);

   assign rdata_o     = r_beat ? rdata : '0;
   assign rdata_valid = r_beat ? grant : '0;
   assign wbeat_ack   = w_beat ? grant : '0;
   assign done        = fin ? grant : '0;
   assign err         = fin && (err_q || beat_err);

   assign arid    = 4'd0;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = 4'd0;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid   = 4'd0;
   assign wdata = wvalid ? req_wdata[DATA_W*gidx +: DATA_W] : '0;
   assign wstrb = wvalid ? (burst_q ? 4'b1111 : req_strb[4*gidx +: 4]) : 4'b0000;
   assign wlast = wvalid && (wcnt == {1'b0, len_q});

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// tb/tb_axi_burst_arbiter.sv - randomized bench for axi_burst_arbiter with port and slave models
module tb_axi_burst_arbiter;
   localparam int NP = 3;
   localparam int BL = 4;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic                aresetn;
   logic [NP-1:0]       req_valid, req_write, req_burst;
   logic [32*NP-1:0]    req_addr;
   logic [2*NP-1:0]     req_size;
   logic [4*NP-1:0]     req_strb;
   logic [32*NP-1:0]    req_wdata;
   logic [NP-1:0]       grant, rdata_valid, wbeat_ack, done;
   logic [31:0]         rdata_o;
   logic                err;
   logic [3:0]          arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
   logic [31:0]         araddr, awaddr, rdata, wdata;
   logic [2:0]          arsize, arprot, awsize, awprot;
   logic [1:0]          arburst, arlock, awburst, awlock, rresp, bresp;
   logic                arvalid, arready, rlast, rvalid, rready;
   logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   axi_burst_arbiter #(.NUM_PORT(NP), .BURST_LEN(BL), .DATA_W(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_write(req_write), .req_burst(req_burst),
      .req_addr(req_addr), .req_size(req_size), .req_strb(req_strb), .req_wdata(req_wdata),
      .grant(grant), .rdata_o(rdata_o), .rdata_valid(rdata_valid), .wbeat_ack(wbeat_ack),
      .done(done), .err(err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int total = 0;
   int bad   = 0;

   // port-side model: one pending request per port
   bit          pend [NP];
   bit          p_wr [NP];
   bit          p_bu [NP];
   logic [31:0] p_addr [NP];
   logic [1:0]  p_size [NP];
   logic [3:0]  p_strb [NP];
   logic [31:0] p_data [NP][BL];
   int          p_beat [NP];
   int          rr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive_ports();
      for (int p = 0; p < NP; p++) begin
         req_valid[p]          = pend[p];
         req_write[p]          = p_wr[p];
         req_burst[p]          = p_bu[p];
         req_addr[32*p +: 32]  = p_addr[p];
         req_size[2*p +: 2]    = p_size[p];
         req_strb[4*p +: 4]    = p_strb[p];
         req_wdata[32*p +: 32] = p_data[p][(p_beat[p] < BL) ? p_beat[p] : BL-1];
      end
   endtask

   task automatic new_req(input int p);
      pend[p]   = 1'b1;
      p_wr[p]   = 1'($urandom_range(0, 1));
      p_bu[p]   = 1'($urandom_range(0, 1));
      p_addr[p] = $urandom;
      p_size[p] = 2'($urandom_range(0, 2));
      p_strb[p] = 4'($urandom);
      p_beat[p] = 0;
      for (int b = 0; b < BL; b++) p_data[p][b] = $urandom;
   endtask

   function automatic int pick();
      for (int i = 0; i < NP; i++)
         if (pend[(rr + i) % NP]) return (rr + i) % NP;
      return 0;
   endfunction

   // Entered at posedge+1 of an idle cycle with ports already driven; returns at posedge+1 of the next idle cycle.
   task automatic serve(input int p);
      logic [NP-1:0] oh;
      logic [31:0]   ea, d;
      logic [3:0]    es;
      logic [1:0]    resp;
      int            nb, waitc, gap;
      bit            eerr;
      oh = '0;
      oh[p] = 1'b1;
      nb = p_bu[p] ? BL : 1;
      ea = p_bu[p] ? p_addr[p] - (p_addr[p] % (BL * 4)) : p_addr[p];
      es = p_bu[p] ? 4'hF : p_strb[p];
      @(negedge aclk);
      chk("idle_grant", grant, '0);
      chk("idle_avalid", {arvalid, awvalid}, 2'b00);
      waitc = 0;
      do begin
         step();
         @(negedge aclk);
         waitc++;
      end while (!(arvalid || awvalid) && waitc < 20);
      chk("addr_latency", waitc, 1);
      chk("grant", grant, oh);
      chk("const_fields", {arid, awid, wid, arlock, arcache, arprot, arburst, awburst}, {24'd0, 2'b01, 2'b01});
      if (!p_wr[p]) begin
         chk("ar_valid", {arvalid, awvalid}, 2'b10);
         chk("araddr", araddr, ea);
         chk("arlen", arlen, nb - 1);
         chk("arsize", arsize, p_bu[p] ? 3'd2 : {1'b0, p_size[p]});
         repeat ($urandom_range(0, 3)) begin
            step();
            @(negedge aclk);
            chk("ar_hold", {arvalid, rready, araddr}, {2'b10, ea});
         end
         step(); arready = 1'b1;
         @(negedge aclk);
         step(); arready = 1'b0;
         eerr = 1'b0;
         for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(negedge aclk);
               chk("r_gap", {rready, rdata_valid, done}, {1'b1, {2*NP{1'b0}}});
               step();
            end
            d = $urandom;
            resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            eerr = eerr | (resp != 2'b00);
            rvalid = 1'b1; rdata = d; rresp = resp; rlast = (b == nb - 1);
            @(negedge aclk);
            chk("rdata_valid", rdata_valid, oh);
            chk("rdata_o", rdata_o, d);
            chk("r_done", done, (b == nb - 1) ? oh : '0);
            if (b == nb - 1) chk("r_err", err, eerr);
            step(); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
         end
      end else begin
         chk("aw_valid", {arvalid, awvalid}, 2'b01);
         chk("awaddr", awaddr, ea);
         chk("awlen", awlen, nb - 1);
         chk("awsize", awsize, p_bu[p] ? 3'd2 : {1'b0, p_size[p]});
         repeat ($urandom_range(0, 3)) begin
            step();
            @(negedge aclk);
            chk("aw_hold", {awvalid, wvalid, awaddr}, {2'b10, ea});
         end
         step(); awready = 1'b1;
         @(negedge aclk);
         step(); awready = 1'b0;
         for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(negedge aclk);
               chk("w_stall", {wvalid, wbeat_ack}, {1'b1, {NP{1'b0}}});
               chk("w_stall_data", wdata, p_data[p][b]);
               step();
            end
            wready = 1'b1;
            @(negedge aclk);
            chk("wvalid", wvalid, 1'b1);
            chk("wdata", wdata, p_data[p][b]);
            chk("wlast", wlast, (b == nb - 1));
            chk("wstrb", wstrb, es);
            chk("wbeat_ack", wbeat_ack, oh);
            step(); wready = 1'b0;
            p_beat[p]++;
            drive_ports();
         end
         repeat ($urandom_range(0, 2)) begin
            @(negedge aclk);
            chk("b_wait", {bready, wvalid, done}, {2'b10, {NP{1'b0}}});
            step();
         end
         resp = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b00;
         bvalid = 1'b1; bresp = resp;
         @(negedge aclk);
         chk("b_done", done, oh);
         chk("b_err", err, resp != 2'b00);
         step(); bvalid = 1'b0; bresp = 2'b00;
      end
   endtask

   initial begin
      int w, waitc;
      bit any;
      aresetn = 1'b0;
      req_valid = '0; req_write = '0; req_burst = '0; req_addr = '0;
      req_size = '0; req_strb = '0; req_wdata = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      rr = 0;
      for (int p = 0; p < NP; p++) begin
         pend[p] = 1'b0; p_wr[p] = 1'b0; p_bu[p] = 1'b0; p_addr[p] = '0;
         p_size[p] = '0; p_strb[p] = '0; p_beat[p] = 0;
         for (int b = 0; b < BL; b++) p_data[p][b] = '0;
      end
      step(); step();
      @(negedge aclk);
      chk("rst_grant", grant, '0);
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'd0);
      chk("rst_strobes", {rdata_valid, wbeat_ack, done, err}, '0);

      step();
      aresetn = 1'b1;
      new_req(0); p_wr[0] = 1'b0; p_bu[0] = 1'b0; p_addr[0] = 32'h1FC0_0004; p_size[0] = 2'd2;
      new_req(1); p_wr[1] = 1'b0; p_bu[1] = 1'b1; p_addr[1] = 32'h0000_1238;
      new_req(2); p_wr[2] = 1'b1; p_bu[2] = 1'b1;
      p_data[2][0] = 32'h11; p_data[2][1] = 32'h22; p_data[2][2] = 32'h33; p_data[2][3] = 32'h44;
      drive_ports();

      for (int t = 0; t < 60; t++) begin
         w = pick();
         serve(w);
         pend[w] = 1'b0;
         rr = (w + 1) % NP;
         any = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 2) != 0) new_req(p);
            any = any | pend[p];
         end
         if (!any) new_req($urandom_range(0, NP - 1));
         drive_ports();
      end

      // abandon a burst read after two beats with a reset
      for (int p = 0; p < NP; p++) pend[p] = 1'b0;
      new_req(0); p_wr[0] = 1'b0; p_bu[0] = 1'b1;
      drive_ports();
      waitc = 0;
      do begin
         step();
         @(negedge aclk);
         waitc++;
      end while (!arvalid && waitc < 20);
      chk("mid_rst_ar", arvalid, 1'b1);
      step(); arready = 1'b1;
      @(negedge aclk);
      step(); arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
         @(negedge aclk);
         chk("mid_rst_beat", {rdata_valid, done}, {{(NP-1){1'b0}}, 1'b1, {NP{1'b0}}});
         step(); rvalid = 1'b0;
      end
      aresetn = 1'b0;
      pend[0] = 1'b0;
      drive_ports();
      step();
      @(negedge aclk);
      chk("mid_rst_grant", grant, '0);
      chk("mid_rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'd0);
      chk("mid_rst_strobes", {rdata_valid, wbeat_ack, done, err}, '0);
      step();
      aresetn = 1'b1;
      rr = 0;
      new_req(1); new_req(2);
      drive_ports();
      for (int t = 0; t < 2; t++) begin
         w = pick();
         serve(w);
         pend[w] = 1'b0;
         rr = (w + 1) % NP;
         drive_ports();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
